instr_mem_arbiter: RTL and testbench

Two-port arbiter in front of the instruction memory (RAM plus boot ROM). It shares the single memory port between the core instruction-fetch interface (port 0) and the debug/loader interface (port 1). It grants one request per cycle, drives the memory enable, address, write and byte-enable lines, and returns a read-valid one cycle later on the granted port. Boot-region writes are blocked.

---
 rtl/instr_arb_pkg.sv | 23 ++
 rtl/instr_arb_starve_cnt.sv | 32 +++
 rtl/instr_mem_arbiter.sv | 107 ++++++++++
 tb/tb_instr_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_arb_pkg : shared types and helpers for the instr-mem arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instr_arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P0   = 2'b01,
        P1   = 2'b10
    } resp_sel_t;

    localparam int unsigned C_MAX_ADDR_W = 64;

    // Boot ROM lives in the upper half of the address space.
    function automatic logic is_boot(input logic [C_MAX_ADDR_W-1:0] addr,
                                     input int unsigned aw);
        return addr[aw-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_arb_starve_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_arb_starve_cnt : saturating denial counter for port 0          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_arb_starve_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expired
);
    localparam logic [7:0] C_LIMIT = 8'(MAX_WAIT);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (clr) begin
            r_cnt <= 8'd0;
        end else if (inc && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expired = (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_arbiter : two-port arbiter for instruction RAM / boot ROM  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_mem_arbiter
    import instr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p0_req_i,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    input  logic                    p1_req_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    wr_err_o
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  w_expired;
    logic                  w_p0_gnt;
    logic                  w_p1_gnt;
    logic                  w_any_gnt;
    logic                  w_boot_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_we;
    logic [BE_W-1:0]       w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    resp_sel_t             r_resp_sel;
    logic                  r_wr_err;

    instr_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (p0_req_i && !w_p0_gnt),
        .clr     (!p0_req_i || w_p0_gnt),
        .expired (w_expired)
    );

    // Port 1 normally wins; an expired counter hands the cycle to port 0.
    always_comb begin
        w_p0_gnt  = p0_req_i && (!p1_req_i || w_expired);
        w_p1_gnt  = p1_req_i && !(p0_req_i && w_expired);
        w_any_gnt = w_p0_gnt || w_p1_gnt;
        w_addr    = p0_addr_i;
        w_we      = p0_we_i;
        w_be      = p0_be_i;
        w_wdata   = p0_wdata_i;
        if (w_p1_gnt) begin
            w_addr  = p1_addr_i;
            w_we    = p1_we_i;
            w_be    = p1_be_i;
            w_wdata = p1_wdata_i;
        end
        w_boot_wr = w_any_gnt && w_we &&
                    is_boot(C_MAX_ADDR_W'(w_addr), ADDR_WIDTH);
    end

    assign p0_gnt_o    = w_p0_gnt;
    assign p1_gnt_o    = w_p1_gnt;
    assign mem_en_o    = !rst && w_any_gnt && !w_boot_wr;
    assign mem_addr_o  = w_addr;
    assign mem_we_o    = w_we && !w_boot_wr;
    assign mem_be_o    = w_be;
    assign mem_wdata_o = w_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_sel <= NONE;
            r_wr_err   <= 1'b0;
        end else begin
            r_resp_sel <= w_p1_gnt ? P1 : (w_p0_gnt ? P0 : NONE);
            r_wr_err   <= w_boot_wr;
        end
    end

    assign p0_rvalid_o = (r_resp_sel == P0);
    assign p1_rvalid_o = (r_resp_sel == P1);
    assign p0_rdata_o  = mem_rdata_i;
    assign p1_rdata_o  = mem_rdata_i;
    assign wr_err_o    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_mem_arbiter : directed vector bench with a small memory     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_mem_arbiter;

    typedef struct {
        logic        rst;
        logic        r0;
        logic [15:0] a0;
        logic        r1;
        logic [15:0] a1;
        logic        we1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic        g0;
        logic        g1;
        logic        en;
        logic [15:0] ea;
        logic        ewe;
        logic [3:0]  ebe;
        logic        rv0;
        logic        rv1;
        logic        err;
        logic        crv;
        logic        crd;
        logic [31:0] erd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we, wr_err;
    logic [15:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic        d1_p0_gnt, d1_p0_rvalid, d1_p1_gnt, d1_p1_rvalid;
    logic [31:0] d1_p0_rdata, d1_p1_rdata;
    logic        d1_mem_en, d1_mem_we, d1_wr_err;
    logic [15:0] d1_mem_addr;
    logic [3:0]  d1_mem_be;
    logic [31:0] d1_mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];
    vec_t        vt  [0:17];

    always #5 clk = ~clk;

    instr_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req), .p0_addr_i(p0_addr), .p0_we_i(p0_we), .p0_be_i(p0_be),
        .p0_wdata_i(p0_wdata), .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_addr_i(p1_addr), .p1_we_i(p1_we), .p1_be_i(p1_be),
        .p1_wdata_i(p1_wdata), .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .wr_err_o(wr_err)
    );

    // Second instance with the tightest starvation limit, sharing all inputs.
    instr_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_WAIT(1)) dut1 (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req), .p0_addr_i(p0_addr), .p0_we_i(p0_we), .p0_be_i(p0_be),
        .p0_wdata_i(p0_wdata), .p0_gnt_o(d1_p0_gnt), .p0_rvalid_o(d1_p0_rvalid), .p0_rdata_o(d1_p0_rdata),
        .p1_req_i(p1_req), .p1_addr_i(p1_addr), .p1_we_i(p1_we), .p1_be_i(p1_be),
        .p1_wdata_i(p1_wdata), .p1_gnt_o(d1_p1_gnt), .p1_rvalid_o(d1_p1_rvalid), .p1_rdata_o(d1_p1_rdata),
        .mem_en_o(d1_mem_en), .mem_addr_o(d1_mem_addr), .mem_we_o(d1_mem_we), .mem_be_o(d1_mem_be),
        .mem_wdata_o(d1_mem_wdata), .mem_rdata_i(mem_rdata), .wr_err_o(d1_wr_err)
    );

    // Memory shared by RAM and ROM, writable everywhere so a leaked ROM write shows up.
    function automatic int idx(input logic [15:0] a);
        return int'({a[15], a[6:2]});
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[idx(mem_addr)][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            mem_rdata <= mem[idx(mem_addr)];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic rst_v, input logic r0, input logic [15:0] a0,
        input logic r1, input logic [15:0] a1, input logic we1,
        input logic [3:0] be1, input logic [31:0] wd1,
        input logic g0, input logic g1, input logic en,
        input logic [15:0] ea, input logic ewe, input logic [3:0] ebe,
        input logic rv0, input logic rv1, input logic err,
        input logic crv, input logic crd, input logic [31:0] erd);
        vec_t v;
        v.rst = rst_v; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.we1 = we1; v.be1 = be1; v.wd1 = wd1;
        v.g0 = g0; v.g1 = g1; v.en = en; v.ea = ea; v.ewe = ewe; v.ebe = ebe;
        v.rv0 = rv0; v.rv1 = rv1; v.err = err; v.crv = crv; v.crd = crd; v.erd = erd;
        return v;
    endfunction

    task automatic drive(input logic rst_v, input logic r0, input logic [15:0] a0,
                         input logic r1, input logic [15:0] a1, input logic we1,
                         input logic [3:0] be1, input logic [31:0] wd1);
        @(negedge clk);
        rst = rst_v; p0_req = r0; p0_addr = a0; p0_we = 1'b0; p0_be = 4'hF;
        p0_wdata = 32'h0; p1_req = r1; p1_addr = a1; p1_we = we1; p1_be = be1;
        p1_wdata = wd1;
        #1;
    endtask

    task automatic apply(input vec_t v, input int r);
        string t;
        t = $sformatf("vec%0d", r);
        drive(v.rst, v.r0, v.a0, v.r1, v.a1, v.we1, v.be1, v.wd1);
        chk({t, ".p0_gnt"},   32'(p0_gnt),   32'(v.g0));
        chk({t, ".p1_gnt"},   32'(p1_gnt),   32'(v.g1));
        chk({t, ".mem_en"},   32'(mem_en),   32'(v.en));
        chk({t, ".mem_addr"}, 32'(mem_addr), 32'(v.ea));
        chk({t, ".mem_we"},   32'(mem_we),   32'(v.ewe));
        chk({t, ".mem_be"},   32'(mem_be),   32'(v.ebe));
        chk({t, ".wr_err"},   32'(wr_err),   32'(v.err));
        if (v.crv) begin
            chk({t, ".p0_rvalid"}, 32'(p0_rvalid), 32'(v.rv0));
            chk({t, ".p1_rvalid"}, 32'(p1_rvalid), 32'(v.rv1));
        end
        if (v.crd) begin
            chk({t, ".p0_rdata"}, p0_rdata, v.erd);
            chk({t, ".p1_rdata"}, p1_rdata, v.erd);
        end
    endtask

    task automatic both_grant(input string t, input logic exp_p0);
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 16'h0020, 1'b0, 4'hF, 32'h0);
        chk({t, ".p0_gnt"}, 32'(p0_gnt), 32'(exp_p0));
        chk({t, ".p1_gnt"}, 32'(p1_gnt), 32'(!exp_p0));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEADBEEF;   // 0x0010
        mem[8]  = 32'h11223344;   // 0x0020
        mem[33] = 32'hB0070004;   // ROM 0x8004

        //           rst r0 a0        r1 a1        we be     wd            g0 g1 en ea        we be    rv0 rv1 err crv crd erd
        vt[0]  = mkv(1, 0, 16'h0000, 0, 16'h0000, 0, 4'hF, 32'h0,        0, 0, 0, 16'h0000, 0, 4'hF, 0, 0, 0, 1, 0, 32'h0);
        vt[1]  = mkv(0, 1, 16'h0010, 0, 16'h0000, 0, 4'hF, 32'h0,        1, 0, 1, 16'h0010, 0, 4'hF, 0, 0, 0, 1, 0, 32'h0);
        vt[2]  = mkv(0, 0, 16'h0000, 0, 16'h0000, 0, 4'hF, 32'h0,        0, 0, 0, 16'h0000, 0, 4'hF, 1, 0, 0, 1, 1, 32'hDEADBEEF);
        vt[3]  = mkv(0, 0, 16'h0000, 1, 16'h8004, 1, 4'hF, 32'h12345678, 0, 1, 0, 16'h8004, 0, 4'hF, 0, 0, 0, 1, 0, 32'h0);
        vt[4]  = mkv(0, 0, 16'h0000, 0, 16'h0000, 0, 4'hF, 32'h0,        0, 0, 0, 16'h0000, 0, 4'hF, 0, 1, 1, 1, 0, 32'h0);
        vt[5]  = mkv(0, 0, 16'h0000, 1, 16'h8004, 0, 4'hF, 32'h0,        0, 1, 1, 16'h8004, 0, 4'hF, 0, 0, 0, 1, 0, 32'h0);
        vt[6]  = mkv(0, 0, 16'h0000, 0, 16'h0000, 0, 4'hF, 32'h0,        0, 0, 0, 16'h0000, 0, 4'hF, 0, 1, 0, 1, 1, 32'hB0070004);
        vt[7]  = mkv(0, 0, 16'h0000, 1, 16'h0020, 1, 4'h2, 32'h0000AB00, 0, 1, 1, 16'h0020, 1, 4'h2, 0, 0, 0, 1, 0, 32'h0);
        vt[8]  = mkv(0, 1, 16'h0020, 0, 16'h0000, 0, 4'hF, 32'h0,        1, 0, 1, 16'h0020, 0, 4'hF, 0, 1, 0, 1, 0, 32'h0);
        vt[9]  = mkv(0, 1, 16'h0010, 0, 16'h0000, 0, 4'hF, 32'h0,        1, 0, 1, 16'h0010, 0, 4'hF, 1, 0, 0, 1, 1, 32'h1122AB44);
        vt[10] = mkv(0, 0, 16'h0000, 1, 16'h0010, 0, 4'hF, 32'h0,        0, 1, 1, 16'h0010, 0, 4'hF, 1, 0, 0, 1, 1, 32'hDEADBEEF);
        vt[11] = mkv(0, 1, 16'h0020, 0, 16'h0000, 0, 4'hF, 32'h0,        1, 0, 1, 16'h0020, 0, 4'hF, 0, 1, 0, 1, 1, 32'hDEADBEEF);
        vt[12] = mkv(0, 0, 16'h0000, 0, 16'h0000, 0, 4'hF, 32'h0,        0, 0, 0, 16'h0000, 0, 4'hF, 1, 0, 0, 1, 1, 32'h1122AB44);
        vt[13] = mkv(0, 1, 16'h0010, 1, 16'h0020, 0, 4'hF, 32'h0,        0, 1, 1, 16'h0020, 0, 4'hF, 0, 0, 0, 1, 0, 32'h0);
        vt[14] = mkv(1, 1, 16'h0010, 1, 16'h0020, 0, 4'hF, 32'h0,        0, 1, 0, 16'h0020, 0, 4'hF, 0, 0, 0, 0, 0, 32'h0);
        vt[15] = mkv(0, 0, 16'h0000, 0, 16'h0000, 0, 4'hF, 32'h0,        0, 0, 0, 16'h0000, 0, 4'hF, 0, 0, 0, 1, 0, 32'h0);
        vt[16] = mkv(0, 1, 16'h0010, 0, 16'h0000, 0, 4'hF, 32'h0,        1, 0, 1, 16'h0010, 0, 4'hF, 0, 0, 0, 1, 0, 32'h0);
        vt[17] = mkv(0, 0, 16'h0000, 0, 16'h0000, 0, 4'hF, 32'h0,        0, 0, 0, 16'h0000, 0, 4'hF, 1, 0, 0, 1, 1, 32'hDEADBEEF);

        for (int r = 0; r < 18; r++) apply(vt[r], r);

        // Continuous contention: 8 denials then a forced port-0 grant; limit 1 alternates.
        for (int k = 0; k < 27; k++) begin
            both_grant($sformatf("cont%0d", k), (k % 9) == 8);
            chk($sformatf("cont%0d.w1_p0_gnt", k), 32'(d1_p0_gnt), 32'((k % 2) == 1));
            chk($sformatf("cont%0d.w1_p1_gnt", k), 32'(d1_p1_gnt), 32'((k % 2) == 0));
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'hF, 32'h0);

        // Dropping port 0's request clears its accumulated wait.
        for (int k = 0; k < 5; k++) both_grant($sformatf("drop_pre%0d", k), 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0020, 1'b0, 4'hF, 32'h0);
        chk("drop.p1_gnt", 32'(p1_gnt), 32'h1);
        for (int k = 0; k < 9; k++) both_grant($sformatf("drop_post%0d", k), k == 8);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'hF, 32'h0);

        // Reset mid-contention clears wait count and pending response.
        for (int k = 0; k < 5; k++) both_grant($sformatf("rst_pre%0d", k), 1'b0);
        drive(1'b1, 1'b1, 16'h0010, 1'b1, 16'h0020, 1'b0, 4'hF, 32'h0);
        chk("rst.mem_en", 32'(mem_en), 32'h0);
        for (int k = 0; k < 9; k++) begin
            both_grant($sformatf("rst_post%0d", k), k == 8);
            if (k == 0) begin
                chk("rst_post0.p0_rvalid", 32'(p0_rvalid), 32'h0);
                chk("rst_post0.p1_rvalid", 32'(p1_rvalid), 32'h0);
            end
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'hF, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
